// File: rtl/printer_job_arbiter.sv
// Round-robin arbiter sharing one printer engine: page counting, start/page-done handshake, fault stall.
// Optional watchdog abort per page enabled by defining PRINTER_ARB_TIMEOUT_EN.
module printer_job_arbiter #(
    parameter int N_REQ       = 4,
    parameter int PAGE_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*PAGE_W-1:0]   req_pages,
    input  logic                      eng_page_done,
    input  logic                      paper_out,
    input  logic                      jam,
    input  logic                      toner_low,
    output logic [N_REQ-1:0]          gnt,
    output logic                      eng_start,
    output logic [N_REQ-1:0]          done,
    output logic                      job_abort,
    output logic [PAGE_W-1:0]         pages_left,
    output logic                      busy,
    output logic                      stalled,
    output logic                      timeout_flag
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        PRINT,
        HOLD,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [PAGE_W-1:0]   pages_q, pages_d;
    logic                page_end_q, page_end_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                eng_start_q, eng_start_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                abort_q, abort_d;
    logic                busy_q, busy_d;
    logic                stalled_q, stalled_d;

    logic                fault;
    logic                owner_req;
    logic                found;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    owner_next;
    int unsigned         rr_idx;

`ifdef PRINTER_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                tflag_q, tflag_d;
    assign timeout_flag = tflag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    // toner_low is a warning consumed elsewhere; it never influences arbitration.
    logic unused_inputs;
    assign unused_inputs = toner_low ^ (TIMEOUT_CYC == 0);

    assign fault      = paper_out | jam;
    assign owner_req  = req[owner_q];
    assign owner_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        found  = 1'b0;
        pick   = '0;
        rr_idx = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rr_idx = (i + 32'(ptr_q)) % 32'(N_REQ);
            if (!found && req[IDX_W'(rr_idx)]) begin
                found = 1'b1;
                pick  = IDX_W'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        pages_d    = pages_q;
        page_end_d = 1'b0;
        gnt_d      = gnt_q;
        abort_d    = 1'b0;
`ifdef PRINTER_ARB_TIMEOUT_EN
        wdog_d     = wdog_q;
        tflag_d    = tflag_q;
`endif
        case (state_q)
            IDLE: begin
                if (found && !fault) begin
                    state_d      = GRANT;
                    owner_d      = pick;
                    gnt_d        = '0;
                    gnt_d[pick]  = 1'b1;
                    pages_d      = req_pages[32'(pick)*PAGE_W +: PAGE_W];
`ifdef PRINTER_ARB_TIMEOUT_EN
                    tflag_d      = 1'b0;
`endif
                end
            end
            GRANT: state_d = (pages_q == '0) ? DONE : START;
            START: begin
                state_d = PRINT;
`ifdef PRINTER_ARB_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            PRINT: begin
                // The decrement lands one edge before the decision so the decision sees the new count.
                if (page_end_q) begin
                    if (pages_q == '0) begin
                        state_d = DONE;
                    end else if (!owner_req) begin
                        state_d = IDLE;
                        abort_d = 1'b1;
                    end else if (fault) begin
                        state_d = HOLD;
                    end else begin
                        state_d = START;
                    end
                end else if (eng_page_done) begin
                    pages_d    = pages_q - 1'b1;
                    page_end_d = 1'b1;
`ifdef PRINTER_ARB_TIMEOUT_EN
                end else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    tflag_d = 1'b1;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
`endif
                end
            end
            HOLD: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (!fault) begin
                    state_d = START;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = owner_next;
            end
            default: state_d = IDLE;
        endcase

        if (abort_d) begin
            gnt_d = '0;
            ptr_d = owner_next;
        end

        eng_start_d = (state_d == START);
        done_d      = (state_d == DONE) ? gnt_q : '0;
        busy_d      = (state_d != IDLE);
        stalled_d   = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            pages_q     <= '0;
            page_end_q  <= 1'b0;
            gnt_q       <= '0;
            eng_start_q <= 1'b0;
            done_q      <= '0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            stalled_q   <= 1'b0;
`ifdef PRINTER_ARB_TIMEOUT_EN
            wdog_q      <= '0;
            tflag_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            pages_q     <= pages_d;
            page_end_q  <= page_end_d;
            gnt_q       <= gnt_d;
            eng_start_q <= eng_start_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            stalled_q   <= stalled_d;
`ifdef PRINTER_ARB_TIMEOUT_EN
            wdog_q      <= wdog_d;
            tflag_q     <= tflag_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign eng_start  = eng_start_q;
    assign done       = done_q;
    assign job_abort  = abort_q;
    assign pages_left = pages_q;
    assign busy       = busy_q;
    assign stalled    = stalled_q;

endmodule

// File: tb/tb_printer_job_arbiter.sv
// Directed bench for printer_job_arbiter: reset, round-robin, page counting, fault hold, zero-page, abort, watchdog.
module tb_printer_job_arbiter;

    localparam int N_REQ  = 4;
    localparam int PAGE_W = 8;
`ifdef PRINTER_ARB_TIMEOUT_EN
    localparam int TCYC = 10;
`else
    localparam int TCYC = 255;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [N_REQ-1:0]         req = '0;
    logic [N_REQ*PAGE_W-1:0]  req_pages = '0;
    logic                     eng_page_done = 1'b0;
    logic                     paper_out = 1'b0;
    logic                     jam = 1'b0;
    logic                     toner_low = 1'b0;
    logic [N_REQ-1:0]         gnt;
    logic                     eng_start;
    logic [N_REQ-1:0]         done;
    logic                     job_abort;
    logic [PAGE_W-1:0]        pages_left;
    logic                     busy;
    logic                     stalled;
    logic                     timeout_flag;

    int errors = 0;
    int checks = 0;

    printer_job_arbiter #(
        .N_REQ      (N_REQ),
        .PAGE_W     (PAGE_W),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_pages    (req_pages),
        .eng_page_done(eng_page_done),
        .paper_out    (paper_out),
        .jam          (jam),
        .toner_low    (toner_low),
        .gnt          (gnt),
        .eng_start    (eng_start),
        .done         (done),
        .job_abort    (job_abort),
        .pages_left   (pages_left),
        .busy         (busy),
        .stalled      (stalled),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_done();
        eng_page_done = 1'b1;
        step(1);
        eng_page_done = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        int n = 0;
        while (eng_start !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        ok = (eng_start === 1'b1);
    endtask

    task automatic test_reset();
        bit ok;
        step(2);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if ({eng_start, job_abort, busy, stalled, timeout_flag} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {eng_start, job_abort, busy, stalled, timeout_flag}); end
        checks++; if (done !== 4'b0000 || pages_left !== 8'd0) begin errors++; $display("FAIL reset_done_pages: got done=%b pages=%0d expected 0000/0", done, pages_left); end
        rst_n = 1'b1;
        step(1);
        req = 4'b0100;
        req_pages[2*PAGE_W +: PAGE_W] = 8'd3;
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_pre_start: got no eng_start expected eng_start within 20 cycles"); end
        step(2);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || pages_left !== 8'd0) begin errors++; $display("FAIL reset_midpage: got gnt=%b busy=%b pages=%0d expected 0000/0/0", gnt, busy, pages_left); end
        req = '0;
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] exp_g [4];
        bit ok;
        int n;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
        req_pages = {8'd1, 8'd1, 8'd1, 8'd1};
        req = 4'b1011;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (gnt === 4'b0000 && n < 20) begin step(1); n++; end
            checks++; if (gnt !== exp_g[j]) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", j, gnt, exp_g[j]); end
            wait_start(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_start%0d: got no eng_start expected eng_start", j); end
            step(2);
            pulse_done();
            step(1);
            checks++; if (done !== exp_g[j]) begin errors++; $display("FAIL rr_done%0d: got %b expected %b", j, done, exp_g[j]); end
            if (j == 3) req = '0;
            step(1);
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_idle%0d: got gnt=%b expected 0000", j, gnt); end
        end
        step(1);
    endtask

    task automatic test_single_job();
        bit ok;
        req_pages[1*PAGE_W +: PAGE_W] = 8'd3;
        req = 4'b0010;
        step(1);
        checks++; if (gnt !== 4'b0010 || pages_left !== 8'd3 || eng_start !== 1'b0) begin errors++; $display("FAIL single_grant: got gnt=%b pages=%0d start=%b expected 0010/3/0", gnt, pages_left, eng_start); end
        step(1);
        checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL single_first_start: got %b expected 1", eng_start); end
        for (int p = 0; p < 3; p++) begin
            wait_start(ok);
            checks++; if (!ok) begin errors++; $display("FAIL single_start%0d: got no eng_start expected eng_start", p); end
            step(4);
            pulse_done();
            checks++; if (pages_left !== 8'(2 - p)) begin errors++; $display("FAIL single_pages%0d: got %0d expected %0d", p, pages_left, 2 - p); end
            step(1);
            if (p < 2) begin
                checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL single_next_start%0d: got %b expected 1", p, eng_start); end
            end else begin
                checks++; if (done !== 4'b0010 || eng_start !== 1'b0) begin errors++; $display("FAIL single_done: got done=%b start=%b expected 0010/0", done, eng_start); end
            end
        end
        req = '0;
        step(1);
        checks++; if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_end: got gnt=%b done=%b busy=%b expected 0000/0000/0", gnt, done, busy); end
        step(1);
    endtask

    task automatic test_fault_hold();
        bit ok;
        req_pages[0 +: PAGE_W] = 8'd2;
        jam = 1'b1;
        req = 4'b0001;
        step(3);
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL fault_idle_block: got gnt=%b busy=%b expected 0000/0", gnt, busy); end
        jam = 1'b0;
        step(1);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL fault_grant: got %b expected 0001", gnt); end
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fault_start: got no eng_start expected eng_start"); end
        step(1);
        jam = 1'b1;
        toner_low = 1'b1;
        step(2);
        pulse_done();
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL fault_page_completes: got stalled=%b expected 0", stalled); end
        step(1);
        checks++; if (stalled !== 1'b1 || eng_start !== 1'b0 || pages_left !== 8'd1) begin errors++; $display("FAIL fault_hold: got stalled=%b start=%b pages=%0d expected 1/0/1", stalled, eng_start, pages_left); end
        step(2);
        checks++; if (stalled !== 1'b1 || eng_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fault_hold_stays: got stalled=%b start=%b busy=%b expected 1/0/1", stalled, eng_start, busy); end
        jam = 1'b0;
        step(1);
        checks++; if (eng_start !== 1'b1 || stalled !== 1'b0) begin errors++; $display("FAIL fault_resume: got start=%b stalled=%b expected 1/0", eng_start, stalled); end
        step(3);
        pulse_done();
        step(1);
        checks++; if (done !== 4'b0001 || stalled !== 1'b0) begin errors++; $display("FAIL fault_toner_done: got done=%b stalled=%b expected 0001/0", done, stalled); end
        req = '0;
        toner_low = 1'b0;
        step(2);
    endtask

    task automatic test_zero_pages();
        req_pages[2*PAGE_W +: PAGE_W] = 8'd0;
        req = 4'b0100;
        step(1);
        checks++; if (gnt !== 4'b0100 || pages_left !== 8'd0) begin errors++; $display("FAIL zero_grant: got gnt=%b pages=%0d expected 0100/0", gnt, pages_left); end
        step(1);
        checks++; if (done !== 4'b0100 || eng_start !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b start=%b expected 0100/0", done, eng_start); end
        req = '0;
        step(1);
        checks++; if (gnt !== 4'b0000 || done !== 4'b0000 || eng_start !== 1'b0) begin errors++; $display("FAIL zero_end: got gnt=%b done=%b start=%b expected 0000/0000/0", gnt, done, eng_start); end
        step(1);
    endtask

    task automatic test_abort();
        bit ok;
        req_pages[3*PAGE_W +: PAGE_W] = 8'd4;
        req = 4'b1000;
        wait_start(ok);
        checks++; if (!ok || gnt !== 4'b1000) begin errors++; $display("FAIL abort_start: got start_ok=%0d gnt=%b expected 1/1000", ok, gnt); end
        step(1);
        req = '0;
        step(2);
        pulse_done();
        checks++; if (pages_left !== 8'd3 || job_abort !== 1'b0) begin errors++; $display("FAIL abort_page_finish: got pages=%0d abort=%b expected 3/0", pages_left, job_abort); end
        step(1);
        checks++; if (job_abort !== 1'b1 || gnt !== 4'b0000 || pages_left !== 8'd3 || eng_start !== 1'b0) begin errors++; $display("FAIL abort_pulse: got abort=%b gnt=%b pages=%0d start=%b expected 1/0000/3/0", job_abort, gnt, pages_left, eng_start); end
        step(1);
        checks++; if (job_abort !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_after: got abort=%b busy=%b expected 0/0", job_abort, busy); end
    endtask

    task automatic test_timeout();
        bit ok;
        req_pages[0 +: PAGE_W] = 8'd2;
        req = 4'b0001;
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_start: got no eng_start expected eng_start"); end
`ifdef PRINTER_ARB_TIMEOUT_EN
        step(10);
        checks++; if (timeout_flag !== 1'b0 || job_abort !== 1'b0) begin errors++; $display("FAIL timeout_early: got flag=%b abort=%b expected 0/0", timeout_flag, job_abort); end
        step(1);
        checks++; if (timeout_flag !== 1'b1 || job_abort !== 1'b1 || gnt !== 4'b0000) begin errors++; $display("FAIL timeout_fire: got flag=%b abort=%b gnt=%b expected 1/1/0000", timeout_flag, job_abort, gnt); end
        step(1);
        checks++; if (timeout_flag !== 1'b0 || gnt !== 4'b0001) begin errors++; $display("FAIL timeout_clear: got flag=%b gnt=%b expected 0/0001", timeout_flag, gnt); end
`else
        step(30);
        checks++; if (timeout_flag !== 1'b0 || job_abort !== 1'b0 || busy !== 1'b1 || pages_left !== 8'd2) begin errors++; $display("FAIL no_timeout_wait: got flag=%b abort=%b busy=%b pages=%0d expected 0/0/1/2", timeout_flag, job_abort, busy, pages_left); end
`endif
        req = '0;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected $finish before 200000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single_job();
        test_fault_hold();
        test_zero_pages();
        test_abort();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/printer_job_arbiter.md
# printer_job_arbiter

Shares one printer engine among N_REQ requesters. Round-robin arbitration, per-job page counting, engine start/page-done handshake, and stalling on blocking faults (paper out, jam) sit in one state machine. The block sits between the host-side job requesters and the printer engine, alongside the alarm decode logic that consumes the same fault inputs.

## Interface
- N_REQ, 4, number of requesters (2..8)
- PAGE_W, 8, width of page counts
- TIMEOUT_CYC, 255, cycles allowed per page before watchdog abort (used only with the macro)

- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  level job request; held until done or dropped to abort
- req_pages  in  N_REQ*PAGE_W  page count of requester i in bits [i*PAGE_W +: PAGE_W]; sampled at grant
- eng_page_done  in  1  one-cycle pulse from engine: current page finished
- paper_out  in  1  blocking fault, level
- jam  in  1  blocking fault, level
- toner_low  in  1  warning only, never blocks
- gnt  out  N_REQ  one-hot owner of the engine; all zero when idle
- eng_start  out  1  one-cycle pulse: engine begins one page
- done  out  N_REQ  one-cycle pulse to owner on normal job completion
- job_abort  out  1  one-cycle pulse when a job ends early
- pages_left  out  PAGE_W  remaining pages of the current job
- busy  out  1  high in every state except IDLE
- stalled  out  1  high while in HOLD
- timeout_flag  out  1  sticky watchdog indication; cleared at next grant

## Operation
- States: IDLE, GRANT, START, PRINT, HOLD, DONE. Reset enters IDLE.
- Outputs are registered. Reset values: gnt=0, done=0, eng_start=0, job_abort=0, pages_left=0, busy=0, stalled=0, timeout_flag=0. The round-robin pointer resets so requester 0 has highest priority.
- IDLE: if any req bit is high and paper_out=jam=0, grant the first active requester at or after the pointer, with wrap-around. Then go to GRANT and load pages_left from that requester's slice. If a blocking fault is active, stay in IDLE.
- GRANT: if pages_left=0, go to DONE (done pulse, no engine activity). Otherwise go to START.
- START: eng_start=1 for exactly this cycle, then go to PRINT.
- PRINT: wait for eng_page_done. On the pulse, decrement pages_left, then decide in this order:
  - pages_left reached 0: go to DONE.
  - owner's req is low: pulse job_abort and go to IDLE.
  - blocking fault active: go to HOLD.
  - otherwise: go to START.
- HOLD: stalled=1. If owner's req drops, pulse job_abort and go to IDLE. Otherwise, when paper_out=jam=0, go to START.
- DONE: done[owner]=1 for this cycle. gnt clears on exit. The pointer moves to owner+1 mod N_REQ. Go to IDLE.
- On job_abort exit, gnt clears and the pointer also advances to owner+1.
- eng_page_done outside PRINT is ignored. A fault arising mid-page does not interrupt the page; it is acted on at page_done.
- A req drop in GRANT/START/PRINT is honoured only at the next page boundary. The page in flight always completes.
- A requester still holding req after its done pulse competes normally; round-robin prevents starvation.
- Asserting rst_n low at any time immediately forces IDLE and all reset values, including mid-page.

## Timing
- req high (no fault, engine free) sampled at edge k: gnt valid after k, eng_start high for the cycle after k+1.
- eng_page_done sampled at edge m:
  - next page: eng_start high for the cycle after m+1.
  - last page: done high for the cycle after m+1.
- Minimum one IDLE cycle between jobs.
- Each HOLD exit costs one START cycle after the fault clears.

## Configuration
- PRINTER_ARB_TIMEOUT_EN defined:
  - A per-page counter clears on entering PRINT.
  - If TIMEOUT_CYC cycles elapse without eng_page_done, set timeout_flag, pulse job_abort, and go to IDLE.
- Not defined: PRINT waits indefinitely and timeout_flag is tied 0.

## Test plan
- Reset mid-page: rst_n low during PRINT -> all outputs 0, state IDLE, next req granted normally.
- Single job: req[1]=1, pages=3, engine returns page_done 5 cycles after each eng_start -> three eng_start pulses, pages_left 3→2→1→0, done[1] pulse, gnt returns to 0.
- Round-robin: req=4'b1011 held, each job 1 page -> grant order 0,1,3,0. The pointer wraps after requester 3.
- Fault hold: jam=1 asserted mid-page of a 2-page job -> stalled=1 after page_done, no eng_start; jam=0 -> eng_start next cycle, job completes. toner_low=1 alone changes nothing.
- Zero pages and abort:
  - pages=0 -> done pulse with no eng_start.
  - req dropped during PRINT of a 4-page job -> current page finishes, job_abort pulse, pages_left holds remainder.
- Timeout (macro on, TIMEOUT_CYC=10): no page_done after eng_start -> timeout_flag=1 and job_abort after 10 cycles; flag clears at next grant.
